// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a run/stop FSM that parks only on a frame boundary.
// Define VGA_FRAME_CNT_EN to add the o_frame counter port.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int XW       = 10,
   parameter int YW       = 10
`ifdef VGA_FRAME_CNT_EN
   ,
   parameter int FW       = 16
`endif
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_pix_stb,
   input  logic          i_run,
   output logic          o_running,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_active,
   output logic          o_line_start,
   output logic          o_frame_start,
   output logic          o_animate,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [FW-1:0] o_frame
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
   localparam logic [XW-1:0] H_ACT_M1 = XW'(H_ACTIVE - 1);
   localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
   localparam logic [YW-1:0] V_ACT_M1 = YW'(V_ACTIVE - 1);
   localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] h_q, h_d;
   logic [YW-1:0] v_q, v_d;
   logic          running_q, running_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          active_q, active_d;
   logic          lineStart_q, lineStart_d;
   logic          frameStart_q, frameStart_d;
   logic          animate_q, animate_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         h_q          <= '0;
         v_q          <= '0;
         running_q    <= 1'b0;
         hs_q         <= ~HS_POL;
         vs_q         <= ~VS_POL;
         active_q     <= 1'b0;
         lineStart_q  <= 1'b0;
         frameStart_q <= 1'b0;
         animate_q    <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         v_q          <= v_d;
         running_q    <= running_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         active_q     <= active_d;
         lineStart_q  <= lineStart_d;
         frameStart_q <= frameStart_d;
         animate_q    <= animate_d;
         x_q          <= x_d;
         y_q          <= y_d;
      end
   end

   // Stopping is only honoured on the last pixel of the frame; otherwise i_run just picks RUN vs DRAIN.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      if (i_pix_stb) begin
         case (state_q)
            IDLE: begin
               if (i_run) state_d = RUN;
            end
            RUN, DRAIN: begin
               if (h_q == H_LAST && v_q == V_LAST && !i_run) begin
                  state_d = IDLE;
                  h_d     = '0;
                  v_d     = '0;
               end else begin
                  state_d = i_run ? RUN : DRAIN;
                  if (h_q == H_LAST) begin
                     h_d = '0;
                     v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                  end else begin
                     h_d = h_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Decoding the next position lets registered outputs line up with the counters they describe.
   always_comb begin
      running_d    = (state_d != IDLE);
      active_d     = running_d && (h_d < H_ACT) && (v_d < V_ACT);
      hs_d         = (running_d && h_d >= HS_BEG && h_d < HS_END) ? HS_POL : ~HS_POL;
      vs_d         = (running_d && v_d >= VS_BEG && v_d < VS_END) ? VS_POL : ~VS_POL;
      x_d          = (h_d < H_ACT) ? h_d : H_ACT_M1;
      y_d          = (v_d < V_ACT) ? v_d : V_ACT_M1;
      lineStart_d  = i_pix_stb && running_d && (h_d == '0);
      frameStart_d = lineStart_d && (v_d == '0);
      animate_d    = lineStart_d && (v_d == V_ACT);
   end

`ifdef VGA_FRAME_CNT_EN
   logic [FW-1:0] frame_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) frame_q <= '0;
      else if (frameStart_d) frame_q <= frame_q + 1'b1;
   end

   assign o_frame = frame_q;
`endif

   assign o_running     = running_q;
   assign o_hs          = hs_q;
   assign o_vs          = vs_q;
   assign o_active      = active_q;
   assign o_line_start  = lineStart_q;
   assign o_frame_start = frameStart_q;
   assign o_animate     = animate_q;
   assign o_x           = x_q;
   assign o_y           = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 14x7 raster (H 8/2/2/2, V 4/1/1/1), active-low syncs.
module tb_vga_timing_gen;

   localparam int HA = 8;
   localparam int HT = 14;
   localparam int VA = 4;
   localparam int VT = 7;
   localparam int FT = HT * VT;
`ifdef VGA_FRAME_CNT_EN
   localparam int FW = 2;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pixStb = 1'b0;
   logic       run = 1'b0;
   logic       oRunning, oHs, oVs, oActive, oLineStart, oFrameStart, oAnimate;
   logic [9:0] oX, oY;
`ifdef VGA_FRAME_CNT_EN
   logic [FW-1:0] oFrame;
`endif

   int assertCount = 0;
   int failCount = 0;

   bit modelLive = 1'b0;
   int modelK = 0;
   bit modelPulse = 1'b0;
   int modelFrame = 0;

   int clkCount = 0;
   int seenLine, seenAnim, seenFs, seenHsLow, seenVsLow, seenIdle, lastFsClk;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .XW(10), .YW(10)
`ifdef VGA_FRAME_CNT_EN
      , .FW(FW)
`endif
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_pix_stb(pixStb),
      .i_run(run),
      .o_running(oRunning),
      .o_hs(oHs),
      .o_vs(oVs),
      .o_active(oActive),
      .o_line_start(oLineStart),
      .o_frame_start(oFrameStart),
      .o_animate(oAnimate),
      .o_x(oX),
      .o_y(oY)
`ifdef VGA_FRAME_CNT_EN
      , .o_frame(oFrame)
`endif
   );

   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at clk %0d: observed %0d, expected %0d", tag, clkCount, observed, expected);
      end
   endtask

   // Expected outputs for the reference position; an idle generator sits at (0,0) with syncs high.
   task automatic checkModel();
      int h, v;
      h = modelK % HT;
      v = modelK / HT;
      if (modelLive) begin
         checkOutput("running", 32'(oRunning), 1);
         checkOutput("active", 32'(oActive), 32'(h < HA && v < VA));
         checkOutput("hs", 32'(oHs), 32'(!(h >= 10 && h < 12)));
         checkOutput("vs", 32'(oVs), 32'(v != 5));
         checkOutput("x", 32'(oX), 32'((h < HA) ? h : HA - 1));
         checkOutput("y", 32'(oY), 32'((v < VA) ? v : VA - 1));
         checkOutput("line_start", 32'(oLineStart), 32'(modelPulse && h == 0));
         checkOutput("frame_start", 32'(oFrameStart), 32'(modelPulse && modelK == 0));
         checkOutput("animate", 32'(oAnimate), 32'(modelPulse && h == 0 && v == VA));
      end else begin
         checkOutput("idle_running", 32'(oRunning), 0);
         checkOutput("idle_active", 32'(oActive), 0);
         checkOutput("idle_hs", 32'(oHs), 1);
         checkOutput("idle_vs", 32'(oVs), 1);
         checkOutput("idle_x", 32'(oX), 0);
         checkOutput("idle_y", 32'(oY), 0);
         checkOutput("idle_pulses", 32'({oLineStart, oFrameStart, oAnimate}), 0);
      end
`ifdef VGA_FRAME_CNT_EN
      checkOutput("frame_cnt", 32'(oFrame), 32'(modelFrame));
`endif
   endtask

   // One clock edge with the given strobe/run; reference position advances, then outputs are checked.
   task automatic applyStimulus(input bit stb, input bit runIn);
      pixStb = stb;
      run = runIn;
      @(posedge clk);
      clkCount++;
      modelPulse = 1'b0;
      if (rst) begin
         modelLive = 1'b0;
         modelK = 0;
         modelFrame = 0;
      end else if (stb) begin
         if (modelLive) begin
            if (modelK == FT - 1 && !runIn) begin
               modelLive = 1'b0;
               modelK = 0;
            end else begin
               modelK = (modelK + 1) % FT;
            end
         end else if (runIn) begin
            modelLive = 1'b1;
            modelK = 0;
         end
         modelPulse = modelLive;
`ifdef VGA_FRAME_CNT_EN
         if (modelPulse && modelK == 0) modelFrame = (modelFrame + 1) % (1 << FW);
`endif
      end
      #1;
      checkModel();
      if (oLineStart) seenLine++;
      if (oAnimate) seenAnim++;
      if (oFrameStart) begin
         seenFs++;
         lastFsClk = clkCount;
      end
      if (!oHs) seenHsLow++;
      if (!oVs) seenVsLow++;
      if (!oRunning) seenIdle++;
   endtask

   task automatic clearSeen();
      seenLine = 0;
      seenAnim = 0;
      seenFs = 0;
      seenHsLow = 0;
      seenVsLow = 0;
      seenIdle = 0;
   endtask

   initial begin
      int base;

      // Reset held with i_run high: nothing may start
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("rst_hs", 32'(oHs), 1);
      checkOutput("rst_vs", 32'(oVs), 1);
      checkOutput("rst_active", 32'(oActive), 0);
      checkOutput("rst_running", 32'(oRunning), 0);

      rst = 1'b0;
      applyStimulus(1'b1, 1'b1);
      checkOutput("first_fs", 32'(oFrameStart), 1);
      checkOutput("first_x", 32'(oX), 0);
      checkOutput("first_active", 32'(oActive), 1);

      // One full free-running frame
      clearSeen();
      for (int i = 0; i < FT; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("frame_line_starts", 32'(seenLine), 7);
      checkOutput("frame_animates", 32'(seenAnim), 1);
      checkOutput("frame_fs_count", 32'(seenFs), 1);
      checkOutput("frame_fs_last", 32'(oFrameStart), 1);
      checkOutput("frame_hs_low", 32'(seenHsLow), 14);
      checkOutput("frame_vs_low", 32'(seenVsLow), 14);

      // Drop i_run at (3,1): keep running to (13,6), then park
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("pos_3_1_x", 32'(oX), 3);
      checkOutput("pos_3_1_y", 32'(oY), 1);
      clearSeen();
      for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("drain_running", 32'(seenIdle), 0);
      checkOutput("drain_hs_at_13_6", 32'(oHs), 1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("parked_running", 32'(oRunning), 0);
      checkOutput("parked_no_fs", 32'(oFrameStart), 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

      // Restart; drop at (3,1), re-raise at (5,2): no gap, next frame_start 98 strobes later
      applyStimulus(1'b1, 1'b1);
      checkOutput("restart_fs", 32'(oFrameStart), 1);
      clearSeen();
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("pos_5_2_x", 32'(oX), 5);
      for (int i = 0; i < 65; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("resume_no_gap", 32'(seenIdle), 0);
      checkOutput("resume_fs_count", 32'(seenFs), 1);
      checkOutput("resume_fs_at_98", 32'(oFrameStart), 1);

      // Strobe on every third clock: one frame spans 294 clocks
      clearSeen();
      base = clkCount;
      lastFsClk = 0;
      for (int c = 1; c <= 3 * FT; c++) applyStimulus((c % 3) == 0, 1'b1);
      checkOutput("slow_fs_count", 32'(seenFs), 1);
      checkOutput("slow_period", 32'(lastFsClk - base), 294);
      checkOutput("slow_line_width", 32'(seenLine), 7);

      // Asynchronous reset at (6,2): outputs drop in the same clock
      for (int i = 0; i < 34; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("pre_rst_x", 32'(oX), 6);
      checkOutput("pre_rst_active", 32'(oActive), 1);
      rst = 1'b1;
      #1;
      modelLive = 1'b0;
      modelK = 0;
      modelFrame = 0;
      checkOutput("async_rst_active", 32'(oActive), 0);
      checkOutput("async_rst_x", 32'(oX), 0);
      checkOutput("async_rst_y", 32'(oY), 0);
      checkModel();
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1);
      #2;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1);
      checkOutput("post_rst_fs", 32'(oFrameStart), 1);

      // Three frames, then five frames since reset
      for (int i = 0; i < 2 * FT; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("third_fs", 32'(oFrameStart), 1);
`ifdef VGA_FRAME_CNT_EN
      checkOutput("frame_cnt_3", 32'(oFrame), 3);
`endif
      for (int i = 0; i < 2 * FT; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("fifth_fs", 32'(oFrameStart), 1);
`ifdef VGA_FRAME_CNT_EN
      checkOutput("frame_cnt_wrap", 32'(oFrame), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
